// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for the unified instruction/data memory.
// Sequences one fixed-latency access at a time and returns a one-cycle ack.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   p0_* (core)           req/we/addr/wdata in, ack/rdata out
//   p1_* (loader/debug)   req/we/addr/wdata in, ack/rdata out
//   mem_en/we/addr/wdata  registered strobes and payload to the memory
//   mem_rdata             memory read data, valid MEM_LAT cycles after mem_en
//   busy                  high whenever the arbiter is not idle
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_t     state;
  logic [3:0] lat_cnt;
  logic       last_grant;
  logic       gnt_id;
  logic       gnt_we;
  logic       pick1;
  logic       req_any;

  assign req_any = p0_req | p1_req;

  // Port choice for this IDLE cycle; only meaningful when req_any.
  // Under contention the port that did not win last time goes next.
  always_comb begin
    pick1 = 1'b0;
    unique case (1'b1)
      (p0_req & p1_req):  pick1 = ~last_grant;
      (p1_req & ~p0_req): pick1 = 1'b1;
      default:            pick1 = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      gnt_we     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_any) begin
            gnt_id    <= pick1;
            gnt_we    <= pick1 ? p1_we : p0_we;
            mem_we    <= pick1 ? p1_we : p0_we;
            mem_addr  <= pick1 ? p1_addr : p0_addr;
            mem_wdata <= pick1 ? p1_wdata : p0_wdata;
            mem_en    <= 1'b1;
            lat_cnt   <= LAT_INIT;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // One write strobe per store, however long the access.
          mem_we <= 1'b0;
          if (lat_cnt == 4'd0) begin
            mem_en     <= 1'b0;
            last_grant <= gnt_id;
            state      <= RESP;
            if (gnt_id) begin
              p1_ack <= 1'b1;
              if (!gnt_we) p1_rdata <= mem_rdata;
            end else begin
              p0_ack <= 1'b1;
              if (!gnt_we) p0_rdata <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP: begin
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Main instance at MEM_LAT=2 plus MEM_LAT=1 and MEM_LAT=5 instances.
module tb_mem_port_arbiter;

  typedef struct {
    int          d;
    bit          port;
    bit          we;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [31:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
  logic        l1_req = 0, l5_req = 0;
  logic [31:0] l_addr = 0;

  logic        u0_a0, u0_a1, u0_en, u0_we, u0_busy;
  logic [31:0] u0_rd0, u0_rd1, u0_maddr, u0_mwd, u0_mrd;
  logic        u1_a0, u1_a1, u1_en, u1_we, u1_busy;
  logic [31:0] u1_rd0, u1_rd1, u1_maddr, u1_mwd, u1_mrd;
  logic        u5_a0, u5_a1, u5_en, u5_we, u5_busy;
  logic [31:0] u5_rd0, u5_rd1, u5_maddr, u5_mwd, u5_mrd;

  logic [31:0] mem [0:255];

  always @(posedge clk) begin
    if (mem_init) mem[4] <= 32'hDEADBEEF;
    else if (u0_en && u0_we) mem[u0_maddr[9:2]] <= u0_mwd;
  end

  assign u0_mrd = mem[u0_maddr[9:2]];
  assign u1_mrd = mem[u1_maddr[9:2]];
  assign u5_mrd = mem[u5_maddr[9:2]];

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) u0 (
    .clk(clk), .rst(rst),
    .p0_req(r0_req), .p0_we(r0_we), .p0_addr(r0_addr),
    .p0_wdata(r0_wdata), .p0_ack(u0_a0), .p0_rdata(u0_rd0),
    .p1_req(r1_req), .p1_we(r1_we), .p1_addr(r1_addr),
    .p1_wdata(r1_wdata), .p1_ack(u0_a1), .p1_rdata(u0_rd1),
    .mem_en(u0_en), .mem_we(u0_we), .mem_addr(u0_maddr),
    .mem_wdata(u0_mwd), .mem_rdata(u0_mrd), .busy(u0_busy)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .p0_req(l1_req), .p0_we(1'b0), .p0_addr(l_addr),
    .p0_wdata(32'h0), .p0_ack(u1_a0), .p0_rdata(u1_rd0),
    .p1_req(1'b0), .p1_we(1'b0), .p1_addr(32'h0),
    .p1_wdata(32'h0), .p1_ack(u1_a1), .p1_rdata(u1_rd1),
    .mem_en(u1_en), .mem_we(u1_we), .mem_addr(u1_maddr),
    .mem_wdata(u1_mwd), .mem_rdata(u1_mrd), .busy(u1_busy)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(5)) u5 (
    .clk(clk), .rst(rst),
    .p0_req(l5_req), .p0_we(1'b0), .p0_addr(l_addr),
    .p0_wdata(32'h0), .p0_ack(u5_a0), .p0_rdata(u5_rd0),
    .p1_req(1'b0), .p1_we(1'b0), .p1_addr(32'h0),
    .p1_wdata(32'h0), .p1_ack(u5_a1), .p1_rdata(u5_rd1),
    .mem_en(u5_en), .mem_we(u5_we), .mem_addr(u5_maddr),
    .mem_wdata(u5_mwd), .mem_rdata(u5_mrd), .busy(u5_busy)
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 5);
  endfunction

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic bit ack_of(input int d, input bit port);
    case (d)
      0:       return port ? u0_a1 : u0_a0;
      1:       return u1_a0;
      default: return u5_a0;
    endcase
  endfunction

  // Monitor: every ack pops the oldest expectation for that instance.
  bit          k0 [3];
  bit          k1 [3];
  bit          ke [3];
  bit          kw [3];
  logic [31:0] kd0 [3];
  logic [31:0] kd1 [3];
  int          encnt [3];
  int          wecnt [3];

  always @(negedge clk) begin
    k0  = '{u0_a0, u1_a0, u5_a0};
    k1  = '{u0_a1, u1_a1, u5_a1};
    ke  = '{u0_en, u1_en, u5_en};
    kw  = '{u0_we, u1_we, u5_we};
    kd0 = '{u0_rd0, u1_rd0, u5_rd0};
    kd1 = '{u0_rd1, u1_rd1, u5_rd1};
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        encnt[k] = 0;
        wecnt[k] = 0;
      end else begin
        if (k0[k] && k1[k]) begin
          total++;
          bad++;
          $display("FAIL dual_ack: dut %0d both acks high", k);
        end
        if (k0[k] || k1[k]) begin
          int   idx;
          exp_t it;
          idx = -1;
          foreach (sbq[i]) if (idx < 0 && sbq[i].d == k) idx = i;
          if (idx < 0) begin
            total++;
            bad++;
            $display("FAIL stray_ack: dut %0d ack p0=%0d p1=%0d, none expected",
                     k, k0[k], k1[k]);
          end else begin
            it = sbq[idx];
            sbq.delete(idx);
            chk("ack_port", 32'(k1[k]), 32'(it.port));
            chk("rdata", k1[k] ? kd1[k] : kd0[k], it.data);
            chk("ack_cycle", cyc, it.cyc);
            chk("en_cycles", encnt[k], lat_of(k));
            chk("we_cycles", wecnt[k], 32'(it.we));
          end
          encnt[k] = 0;
          wecnt[k] = 0;
        end
        if (ke[k]) encnt[k]++;
        if (kw[k]) wecnt[k]++;
      end
    end
  end

  task automatic drive(input int d, input bit port, input bit req,
                       input bit we, input logic [31:0] addr,
                       input logic [31:0] wd);
    case (d)
      0: begin
        if (port) begin
          r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wd;
        end else begin
          r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wd;
        end
      end
      1: begin l1_req = req; l_addr = addr; end
      default: begin l5_req = req; l_addr = addr; end
    endcase
  endtask

  // Called one step after a rising edge with the arbiter idle.
  task automatic txn(input int d, input bit port, input bit we,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp);
    exp_t it;
    int   n;
    it.d    = d;
    it.port = port;
    it.we   = we;
    it.data = exp;
    it.cyc  = cyc + 1 + lat_of(d);
    sbq.push_back(it);
    drive(d, port, 1'b1, we, addr, wd);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_of(d, port) && n < 40);
    if (!ack_of(d, port)) begin
      total++;
      bad++;
      $display("FAIL txn_timeout: dut %0d port %0d no ack", d, port);
    end
    @(posedge clk);
    #1;
    drive(d, port, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Both ports read continuously; grants must alternate from port 0.
  task automatic contend(input int num);
    exp_t it;
    int   n;
    int   t;
    for (int k = 0; k < num; k++) begin
      it.d    = 0;
      it.port = k[0];
      it.we   = 1'b0;
      it.data = k[0] ? 32'h12345678 : 32'hDEADBEEF;
      it.cyc  = cyc + 3 + 4 * k;
      sbq.push_back(it);
    end
    drive(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    n = 0;
    t = 0;
    while (n < num && t < 100) begin
      @(negedge clk);
      t++;
      if (u0_a0 || u0_a1) n++;
    end
    if (n < num) begin
      total++;
      bad++;
      $display("FAIL contend_timeout: got %0d acks want %0d", n, num);
    end
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_init = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_quiet",
          32'(u0_a0 | u0_a1 | u0_en | u0_we | u0_busy |
              (|u0_maddr) | (|u0_mwd) | (|u0_rd0) | (|u0_rd1)),
          32'h0);
    end
    @(posedge clk);
    #1;

    txn(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    chk("p0_rdata_held", u0_rd0, 32'hDEADBEEF);
    @(posedge clk);
    #1;

    txn(0, 1'b1, 1'b1, 32'h40, 32'h12345678, 32'h0);
    txn(0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h12345678);

    contend(4);

    drive(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_pre_busy", 32'(u0_busy), 32'h1);
    chk("rst_pre_en", 32'(u0_en), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_en", 32'(u0_en), 32'h0);
    chk("rst_mid_busy", 32'(u0_busy), 32'h0);
    chk("rst_mid_ack", 32'(u0_a0 | u0_a1), 32'h0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;

    contend(2);

    txn(1, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    txn(2, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
